// File: rtl/gen_tm.sv
// Time-mark window generator: a start edge arms the block, the next ce tick
// opens Tm, and Tm stays high for exactly TM_LEN ce ticks.
module gen_tm #(
    parameter int unsigned TM_LEN = 1000,
    parameter int unsigned CNT_W  = $clog2(TM_LEN + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic st,
    input  logic ce,
    output logic Tm
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACTIVE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TM_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             st_q, st_d;
    logic             tm_q, tm_d;
    logic             st_edge;

    // st_q resets to 0, so st held high through reset release is an edge
    always_comb begin
        st_d    = st;
        st_edge = st & ~st_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tm_d    = tm_q;
        unique case (state_q)
            IDLE: begin
                tm_d  = 1'b0;
                cnt_d = '0;
                if (st_edge) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (ce) begin
                    state_d = ACTIVE;
                    tm_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                if (ce) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        tm_d    = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tm_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= 1'b0;
            tm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            tm_q    <= tm_d;
        end
    end

    assign Tm = tm_q;

endmodule

// File: tb/tb_gen_tm.sv
// Self-checking bench for gen_tm (TM_LEN=4): directed scenarios plus random
// stimulus, each cycle compared against a countdown-based reference model.
module tb_gen_tm;

    localparam int unsigned TM_LEN = 4;

    logic clk;
    logic rst_n;
    logic st;
    logic ce;
    logic Tm;

    gen_tm #(.TM_LEN(TM_LEN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .st   (st),
        .ce   (ce),
        .Tm   (Tm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: a window is "remaining ticks to count down"
    bit          m_armed;
    int unsigned m_rem;
    bit          m_prev;
    logic        exp_tm;

    // Stimulus bookkeeping
    bit          ce_stuck;
    int unsigned phase;
    int          cyc;
    int          rise_cyc;
    int          fall_cyc;
    int          windows;
    logic        tm_prev;
    int          st_cyc;
    int          w0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_rem   = 0;
        m_prev  = 1'b0;
    endtask

    task automatic model_update();
        bit e;
        if (!rst_n) begin
            model_reset();
        end else begin
            e = st && !m_prev;
            if (m_rem > 0) begin
                if (ce) m_rem--;
            end else if (m_armed) begin
                if (ce) begin
                    m_rem   = TM_LEN;
                    m_armed = 1'b0;
                end
            end else if (e) begin
                m_armed = 1'b1;
            end
            m_prev = st;
        end
        exp_tm = (m_rem != 0);
    endtask

    task automatic step(input logic st_v, input logic rst_v);
        st    = st_v;
        ce    = ce_stuck ? 1'b1 : (phase == 4);
        phase = (phase + 1) % 5;
        rst_n = rst_v;
        if (!rst_v) begin
            model_reset();
            exp_tm = 1'b0;
        end
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        check("tm_model", {31'd0, Tm}, {31'd0, exp_tm});
        if (Tm === 1'b1 && tm_prev === 1'b0) begin
            rise_cyc = cyc;
            windows++;
        end
        if (Tm === 1'b0 && tm_prev === 1'b1) fall_cyc = cyc;
        tm_prev = Tm;
    endtask

    initial begin
        rst_n    = 1'b0;
        st       = 1'b0;
        ce       = 1'b0;
        ce_stuck = 1'b0;
        phase    = 0;
        cyc      = 0;
        rise_cyc = 0;
        fall_cyc = 0;
        windows  = 0;
        tm_prev  = 1'b0;
        exp_tm   = 1'b0;
        model_reset();

        // 1. reset with st/ce toggling, then idle after release
        #1;
        check("reset_tm", {31'd0, Tm}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            ce_stuck = (i % 2 == 1);
            step(logic'($urandom_range(0, 1)), 1'b0);
        end
        ce_stuck = 1'b0;
        step(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        check("idle_no_window", windows, 32'd0);

        // 2. nominal: 1-clk st pulse two edges before a ce
        phase = 2;
        step(1'b1, 1'b1);
        st_cyc = cyc;
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
        check("nom_rise_lat", rise_cyc - st_cyc, 32'd2);
        check("nom_width", fall_cyc - rise_cyc, 32'd20);
        check("nom_windows", windows, 32'd1);

        // 3. st held 30 clk: one window only
        w0 = windows;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        check("long_st_windows", windows - w0, 32'd1);
        check("long_st_width", fall_cyc - rise_cyc, 32'd20);

        // 4. retrigger mid-window is ignored; fresh edge after fall restarts
        w0 = windows;
        step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1);
        check("retrig_windows", windows - w0, 32'd1);
        check("retrig_width", fall_cyc - rise_cyc, 32'd20);
        step(1'b1, 1'b1);
        for (int i = 0; i < 28; i++) step(1'b0, 1'b1);
        check("restart_windows", windows - w0, 32'd2);

        // 5. ce stuck high
        ce_stuck = 1'b1;
        step(1'b1, 1'b1);
        st_cyc = cyc;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        check("stuck_rise_lat", rise_cyc - st_cyc, 32'd1);
        check("stuck_width", fall_cyc - rise_cyc, 32'd4);
        ce_stuck = 1'b0;

        // 6. reset mid-window drops Tm asynchronously
        step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        check("pre_rst_tm", {31'd0, Tm}, 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        exp_tm = 1'b0;
        #1;
        check("rst_async_tm", {31'd0, Tm}, 32'd0);
        tm_prev = Tm;
        for (int i = 0; i < 3; i++) step(logic'(i % 2), 1'b0);
        w0 = windows;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        check("post_rst_idle", windows - w0, 32'd0);

        // st held through reset release counts as an edge
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
        check("st_thru_rst", windows - w0, 32'd1);
        step(1'b0, 1'b1);

        // random stimulus against the model
        for (int seg = 0; seg < 12; seg++) begin
            ce_stuck = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 40; i++) begin
                logic s;
                logic r;
                s = ($urandom_range(0, 6) == 0) ? ~st : st;
                r = ($urandom_range(0, 60) != 0);
                step(s, r);
            end
        end
        ce_stuck = 1'b0;
        step(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
